// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: refill FSM states, the nop word loaded into
// IF/ID on a miss, and line-offset geometry.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_FILL   = 2'd2,
      ST_REPLAY = 2'd3
   } state_t;

   // add $0 $0 $0
   localparam logic [31:0] NOP_INSTR = 32'd32;

   // Byte-offset bits covered by one line: word index bits plus 2 byte bits.
   function automatic int line_off_bits(input int words_per_line);
      return $clog2(words_per_line) + 2;
   endfunction

   // Offset bits for the default 4-word line.
   localparam int LINE_OFF_BITS = line_off_bits(4);

endpackage

// File: rtl/icache_refill_controller_if.sv
// Fetch / cache-fill / memory bus of the refill controller.
// master = the refill controller, slave = fetch stage, cache and memory.
interface icache_refill_controller_if #(
   parameter int WORDS_PER_LINE = 4,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int CNT_W          = 16
);
   localparam int IDX_W = $clog2(WORDS_PER_LINE);

   logic              fetch_valid;
   logic [ADDR_W-1:0] fetch_addr;
   logic              cache_hit;
   logic              flush;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              fill_we;
   logic [IDX_W-1:0]  fill_index;
   logic [DATA_W-1:0] fill_data;
   logic              pc_stall;
   logic              fetch_hit;
   logic [CNT_W-1:0]  miss_count;

   modport master (
      input  fetch_valid, fetch_addr, cache_hit, flush,
      input  mem_ready, mem_rvalid, mem_rdata,
      output mem_req, mem_addr, fill_we, fill_index, fill_data,
      output pc_stall, fetch_hit, miss_count
   );

   modport slave (
      output fetch_valid, fetch_addr, cache_hit, flush,
      output mem_ready, mem_rvalid, mem_rdata,
      input  mem_req, mem_addr, fill_we, fill_index, fill_data,
      input  pc_stall, fetch_hit, miss_count
   );
endinterface

// File: rtl/icache_refill_controller_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             i_clr_n,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count
);
   logic [WIDTH-1:0] r_count;

   // Count enabled events until all-ones; async clear to zero.
   always_ff @(posedge clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_count <= '0;
      end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;
endmodule

// File: rtl/icache_refill_controller.sv
// Instruction-cache miss refill sequencer. Stalls the PC and feeds the IF/ID
// register a not-hit (nop) on a miss, fetches the line with a request/burst
// handshake, writes it into the cache and then releases fetch for a replay.
module icache_refill_controller
   import fetch_pkg::*;
#(
   parameter int WORDS_PER_LINE = 4,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int CNT_W          = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   icache_refill_controller_if.master  bus
);
   localparam int                IDX_W     = $clog2(WORDS_PER_LINE);
   localparam int                OFF_BITS  = line_off_bits(WORDS_PER_LINE);
   localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_BITS;
   localparam logic [IDX_W-1:0]  LAST_WORD = IDX_W'(WORDS_PER_LINE - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_miss_addr;
   logic [IDX_W-1:0]  r_word_cnt;
   logic              w_miss;
   logic              w_last_word;

   // A miss only starts a refill from IDLE, and a redirect cancels it.
   assign w_miss      = (r_state == ST_IDLE) & bus.fetch_valid & ~bus.cache_hit & ~bus.flush;
   assign w_last_word = bus.mem_rvalid & (r_word_cnt == LAST_WORD);

   // State register; reset aborts any refill in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; flush is deliberately ignored once a refill has begun.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_miss)         w_state_next = ST_REQ;
         ST_REQ:    if (bus.mem_ready)  w_state_next = ST_FILL;
         ST_FILL:   if (w_last_word)    w_state_next = ST_REPLAY;
         ST_REPLAY:                     w_state_next = ST_IDLE;
         default:                       w_state_next = ST_IDLE;
      endcase
   end

   // Miss address capture and burst word counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_miss_addr <= '0;
         r_word_cnt  <= '0;
      end else begin
         if (w_miss) begin
            r_miss_addr <= bus.fetch_addr;
         end
         if ((r_state == ST_REQ) && bus.mem_ready) begin
            r_word_cnt <= '0;
         end else if ((r_state == ST_FILL) && bus.mem_rvalid) begin
            // Wraps back to 0 after the last word of the line.
            r_word_cnt <= r_word_cnt + IDX_W'(1);
         end
      end
   end

   // Outputs: memory request, cache fill strobe, and fetch stall/hit controls.
   always_comb begin
      bus.mem_req    = (r_state == ST_REQ);
      bus.mem_addr   = r_miss_addr & LINE_MASK;
      bus.fill_we    = (r_state == ST_FILL) & bus.mem_rvalid;
      bus.fill_index = r_word_cnt;
      bus.fill_data  = bus.mem_rdata;
      bus.pc_stall   = (r_state != ST_IDLE) | w_miss;
      bus.fetch_hit  = (r_state == ST_IDLE) & bus.fetch_valid & bus.cache_hit & ~bus.flush;
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_miss_cnt (
      .clk     (clk),
      .i_clr_n (reset),
      .i_en    (w_miss),
      .o_count (bus.miss_count)
   );
endmodule

// File: tb/tb_icache_refill_controller.sv
// Directed bench for icache_refill_controller. A second instance with a 2-bit
// miss counter shares the same inputs to exercise counter saturation.
module tb_icache_refill_controller;
   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   icache_refill_controller_if #(.CNT_W(16)) bus   ();
   icache_refill_controller_if #(.CNT_W(2))  bus_s ();

   icache_refill_controller #(.CNT_W(16)) u_dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   icache_refill_controller #(.CNT_W(2)) u_dut_sat (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus_s)
   );

   assign bus_s.fetch_valid = bus.fetch_valid;
   assign bus_s.fetch_addr  = bus.fetch_addr;
   assign bus_s.cache_hit   = bus.cache_hit;
   assign bus_s.flush       = bus.flush;
   assign bus_s.mem_ready   = bus.mem_ready;
   assign bus_s.mem_rvalid  = bus.mem_rvalid;
   assign bus_s.mem_rdata   = bus.mem_rdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.fetch_valid = 1'b0;
      bus.fetch_addr  = '0;
      bus.cache_hit   = 1'b0;
      bus.flush       = 1'b0;
      bus.mem_ready   = 1'b0;
      bus.mem_rvalid  = 1'b0;
      bus.mem_rdata   = '0;
   endtask

   // One complete refill; the line is filled with base+0 .. base+3.
   task automatic refill(input logic [31:0] addr, input int ready_wait, input bit gap,
                         input bit flush_fill, input logic [31:0] base,
                         input int exp_cnt, input int exp_sat);
      logic [31:0] line;
      line = addr & 32'hFFFF_FFF0;
      // miss cycle in IDLE
      bus.fetch_valid = 1'b1;
      bus.fetch_addr  = addr;
      bus.cache_hit   = 1'b0;
      bus.flush       = 1'b0;
      bus.mem_ready   = 1'b0;
      bus.mem_rvalid  = 1'b0;
      #1;
      chk("miss_stall", 64'(bus.pc_stall), 64'd1);
      chk("miss_hit", 64'(bus.fetch_hit), 64'd0);
      chk("miss_req", 64'(bus.mem_req), 64'd0);
      // REQ: wait states, then handshake
      for (int i = 0; i < ready_wait; i++) begin
         tick();
         bus.mem_ready = 1'b0;
         #1;
         chk("req_wait", 64'(bus.mem_req), 64'd1);
         chk("req_wait_addr", 64'(bus.mem_addr), 64'(line));
         chk("req_wait_stall", 64'(bus.pc_stall), 64'd1);
      end
      tick();
      bus.mem_ready = 1'b1;
      #1;
      chk("req", 64'(bus.mem_req), 64'd1);
      chk("req_addr", 64'(bus.mem_addr), 64'(line));
      // FILL
      for (int w = 0; w < 4; w++) begin
         if (gap && (w == 2)) begin
            tick();
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.flush      = 1'b0;
            #1;
            chk("gap_we", 64'(bus.fill_we), 64'd0);
            chk("gap_stall", 64'(bus.pc_stall), 64'd1);
         end
         tick();
         bus.mem_ready  = 1'b0;
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = base + 32'(w);
         bus.flush      = flush_fill && (w == 1);
         #1;
         chk("fill_we", 64'(bus.fill_we), 64'd1);
         chk("fill_index", 64'(bus.fill_index), 64'(w));
         chk("fill_data", 64'(bus.fill_data), 64'(base + 32'(w)));
         chk("fill_stall", 64'(bus.pc_stall), 64'd1);
         chk("fill_req", 64'(bus.mem_req), 64'd0);
      end
      // REPLAY: the cache now holds the line
      tick();
      bus.mem_rvalid = 1'b0;
      bus.flush      = 1'b0;
      bus.cache_hit  = 1'b1;
      #1;
      chk("replay_stall", 64'(bus.pc_stall), 64'd1);
      chk("replay_we", 64'(bus.fill_we), 64'd0);
      chk("replay_hit", 64'(bus.fetch_hit), 64'd0);
      // back in IDLE, lookup hits
      tick();
      chk("done_stall", 64'(bus.pc_stall), 64'd0);
      chk("done_hit", 64'(bus.fetch_hit), 64'd1);
      chk("done_req", 64'(bus.mem_req), 64'd0);
      chk("miss_count", 64'(bus.miss_count), 64'(exp_cnt));
      chk("miss_count_sat", 64'(bus_s.miss_count), 64'(exp_sat));
      $display("refill addr=%08h line=%08h wait=%0d gap=%0d flush=%0d count=%0d",
               addr, line, ready_wait, gap, flush_fill, bus.miss_count);
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      #1;
      // reset state
      chk("rst_req", 64'(bus.mem_req), 64'd0);
      chk("rst_we", 64'(bus.fill_we), 64'd0);
      chk("rst_index", 64'(bus.fill_index), 64'd0);
      chk("rst_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_count", 64'(bus.miss_count), 64'd0);
      chk("rst_stall", 64'(bus.pc_stall), 64'd0);
      chk("rst_hit", 64'(bus.fetch_hit), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // 1. hit path
      for (int i = 0; i < 10; i++) begin
         tick();
         bus.fetch_valid = 1'b1;
         bus.fetch_addr  = 32'h0000_0100 + 32'(4 * i);
         bus.cache_hit   = 1'b1;
         #1;
         chk("hit_hit", 64'(bus.fetch_hit), 64'd1);
         chk("hit_stall", 64'(bus.pc_stall), 64'd0);
         chk("hit_req", 64'(bus.mem_req), 64'd0);
      end
      $display("hit path 10 cycles");
      tick();
      chk("hit_count", 64'(bus.miss_count), 64'd0);

      // 2. single miss, fastest memory
      refill(32'h0000_1234, 0, 1'b0, 1'b0, 32'h0000_00A0, 1, 1);

      // 3. slow memory: 3 wait cycles and a gap before word 2
      tick();
      refill(32'h0000_BEEF, 3, 1'b1, 1'b0, 32'h0000_00B0, 2, 2);

      // 4a. flush in IDLE with a miss and with a hit
      tick();
      bus.fetch_valid = 1'b1;
      bus.fetch_addr  = 32'h0000_4000;
      bus.cache_hit   = 1'b0;
      bus.flush       = 1'b1;
      #1;
      chk("flush_miss_stall", 64'(bus.pc_stall), 64'd0);
      chk("flush_miss_hit", 64'(bus.fetch_hit), 64'd0);
      tick();
      bus.cache_hit = 1'b1;
      #1;
      chk("flush_idle_req", 64'(bus.mem_req), 64'd0);
      chk("flush_hit_hit", 64'(bus.fetch_hit), 64'd0);
      chk("flush_count", 64'(bus.miss_count), 64'd2);
      $display("flush in idle");

      // 4b. flush during FILL does not abort the refill
      tick();
      refill(32'h8000_001C, 0, 1'b0, 1'b1, 32'h0000_00C0, 3, 3);

      // 5. reset in the middle of FILL
      tick();
      bus.fetch_valid = 1'b1;
      bus.fetch_addr  = 32'h0000_2008;
      bus.cache_hit   = 1'b0;
      tick();
      bus.mem_ready = 1'b1;
      #1;
      chk("rst5_req", 64'(bus.mem_req), 64'd1);
      for (int w = 0; w < 2; w++) begin
         tick();
         bus.mem_ready  = 1'b0;
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = 32'h0000_00D0 + 32'(w);
      end
      tick();
      bus.mem_rdata = 32'h0000_00D2;
      #1;
      chk("rst5_pre_we", 64'(bus.fill_we), 64'd1);
      chk("rst5_pre_index", 64'(bus.fill_index), 64'd2);
      rst_n = 1'b0;
      #1;
      chk("rst5_req0", 64'(bus.mem_req), 64'd0);
      chk("rst5_we0", 64'(bus.fill_we), 64'd0);
      chk("rst5_count0", 64'(bus.miss_count), 64'd0);
      chk("rst5_index0", 64'(bus.fill_index), 64'd0);
      chk("rst5_addr0", 64'(bus.mem_addr), 64'd0);
      bus.fetch_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.mem_rvalid = 1'b1;
      #1;
      chk("stray_we", 64'(bus.fill_we), 64'd0);
      chk("stray_stall", 64'(bus.pc_stall), 64'd0);
      tick();
      chk("stray_we2", 64'(bus.fill_we), 64'd0);
      chk("stray_req", 64'(bus.mem_req), 64'd0);
      chk("stray_count", 64'(bus.miss_count), 64'd0);
      bus.mem_rvalid = 1'b0;
      $display("reset mid-fill");

      // 6. saturation of the 2-bit counter over 5 misses
      for (int n = 1; n <= 5; n++) begin
         tick();
         refill(32'h0001_0000 + 32'(16 * n), 0, 1'b0, 1'b0, 32'h0000_0E00 + 32'(16 * n),
                n, (n > 3) ? 3 : n);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
